// File: rtl/idu_pkg.sv
// Shared RV32I decode types: instruction format codes and base opcode values.
// Imported by the decoder top level and the immediate generator.
package idu_pkg;

    typedef enum logic [2:0] {
        TYPE_R       = 3'b000,
        TYPE_I       = 3'b001,
        TYPE_S       = 3'b010,
        TYPE_B       = 3'b011,
        TYPE_U       = 3'b100,
        TYPE_J       = 3'b101,
        TYPE_UNKNOWN = 3'b111
    } instr_type_e;

    localparam logic [6:0] OPCODE_R_TYPE = 7'b0110011;
    localparam logic [6:0] OPCODE_I_TYPE = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;

    // Shift-immediates reuse the I format but carry funct7 and a 5-bit shamt.
    function automatic logic is_i_shift(input logic [6:0] op, input logic [2:0] f3);
        return (op == OPCODE_I_TYPE) && ((f3 == 3'b001) || (f3 == 3'b101));
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: builds the 32-bit immediate for the decoded format.
// Purely combinational, zero latency; no flow control.
module imm_gen
    import idu_pkg::*;
(
    input  logic [31:0] instruction,
    input  instr_type_e instr_type,
    output logic [31:0] imm
);

    always_comb begin
        imm = '0;
        case (instr_type)
            TYPE_I: begin
                if (is_i_shift(instruction[6:0], instruction[14:12]))
                    imm = {27'b0, instruction[24:20]};
                else
                    imm = {{20{instruction[31]}}, instruction[31:20]};
            end
            TYPE_S: imm = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
            TYPE_B: imm = {{19{instruction[31]}}, instruction[31], instruction[7],
                           instruction[30:25], instruction[11:8], 1'b0};
            TYPE_U: imm = {instruction[31:12], 12'b0};
            TYPE_J: imm = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                           instruction[20], instruction[30:21], 1'b0};
            default: imm = '0;
        endcase
    end

endmodule

// File: rtl/instruction_decode_unit.sv
// RV32I decode stage: classifies format, muxes fields, registers all outputs.
// Latency 1 cycle; no backpressure. Optional `illegal` output via IDU_ILLEGAL_CHECK_EN.
module instruction_decode_unit
    import idu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [31:0] instruction,
    output logic        out_valid,
    output logic [6:0]  opcode,
    output logic [4:0]  rd,
    output logic [2:0]  funct3,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [6:0]  funct7,
    output logic [31:0] imm,
`ifdef IDU_ILLEGAL_CHECK_EN
    output logic        illegal,
`endif
    output logic [2:0]  instr_type
);

    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    instr_type_e type_d;
    logic [4:0]  rd_d, rs1_d, rs2_d;
    logic [2:0]  f3_d;
    logic [6:0]  f7_d;
    logic [31:0] imm_d;

    assign op = instruction[6:0];
    assign f3 = instruction[14:12];
    assign f7 = instruction[31:25];

    always_comb begin
        type_d = TYPE_UNKNOWN;
        case (op)
            OPCODE_R_TYPE:                          type_d = TYPE_R;
            OPCODE_I_TYPE, OPCODE_LOAD, OPCODE_JALR: type_d = TYPE_I;
            OPCODE_STORE:                           type_d = TYPE_S;
            OPCODE_BRANCH:                          type_d = TYPE_B;
            OPCODE_LUI, OPCODE_AUIPC:               type_d = TYPE_U;
            OPCODE_JAL:                             type_d = TYPE_J;
            default:                                type_d = TYPE_UNKNOWN;
        endcase
    end

    // Fields the format does not define are forced to zero.
    always_comb begin
        rd_d  = '0;
        f3_d  = '0;
        rs1_d = '0;
        rs2_d = '0;
        f7_d  = '0;
        case (type_d)
            TYPE_R: begin
                rd_d  = instruction[11:7];
                f3_d  = f3;
                rs1_d = instruction[19:15];
                rs2_d = instruction[24:20];
                f7_d  = f7;
            end
            TYPE_I: begin
                rd_d  = instruction[11:7];
                f3_d  = f3;
                rs1_d = instruction[19:15];
                if (is_i_shift(op, f3))
                    f7_d = f7;
            end
            TYPE_S, TYPE_B: begin
                f3_d  = f3;
                rs1_d = instruction[19:15];
                rs2_d = instruction[24:20];
            end
            TYPE_U, TYPE_J: rd_d = instruction[11:7];
            default: ;
        endcase
    end

    imm_gen u_imm_gen (
        .instruction (instruction),
        .instr_type  (type_d),
        .imm         (imm_d)
    );

`ifdef IDU_ILLEGAL_CHECK_EN
    logic illegal_d;

    always_comb begin
        illegal_d = 1'b0;
        case (type_d)
            TYPE_UNKNOWN: illegal_d = 1'b1;
            TYPE_R: illegal_d = (f7 != 7'b0000000) &&
                                !((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
            TYPE_I: begin
                if (is_i_shift(op, f3))
                    illegal_d = (f3 == 3'b001) ? (f7 != 7'b0000000)
                                               : !((f7 == 7'b0000000) || (f7 == 7'b0100000));
                else if (op == OPCODE_JALR)
                    illegal_d = (f3 != 3'b000);
                else if (op == OPCODE_LOAD)
                    illegal_d = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
            end
            TYPE_B: illegal_d = (f3 == 3'b010) || (f3 == 3'b011);
            TYPE_S: illegal_d = (f3 > 3'b010);
            default: illegal_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            illegal <= 1'b0;
        else if (in_valid)
            illegal <= illegal_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid  <= 1'b0;
            opcode     <= '0;
            rd         <= '0;
            funct3     <= '0;
            rs1        <= '0;
            rs2        <= '0;
            funct7     <= '0;
            imm        <= '0;
            instr_type <= TYPE_UNKNOWN;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                opcode     <= op;
                rd         <= rd_d;
                funct3     <= f3_d;
                rs1        <= rs1_d;
                rs2        <= rs2_d;
                funct7     <= f7_d;
                imm        <= imm_d;
                instr_type <= type_d;
            end
        end
    end

endmodule

// File: tb/tb_instruction_decode_unit.sv
// Self-checking bench for instruction_decode_unit: directed vectors plus random
// stimulus against a format-table reference model.
module tb_instruction_decode_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] instruction = '0;
    logic        out_valid;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [2:0]  funct3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic [2:0]  instr_type;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    instruction_decode_unit dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .instruction (instruction),
        .out_valid   (out_valid),
        .opcode      (opcode),
        .rd          (rd),
        .funct3      (funct3),
        .rs1         (rs1),
        .rs2         (rs2),
        .funct7      (funct7),
        .imm         (imm),
`ifdef IDU_ILLEGAL_CHECK_EN
        .illegal     (illegal),
`endif
        .instr_type  (instr_type)
    );

`ifndef IDU_ILLEGAL_CHECK_EN
    assign illegal = 1'b0;
`endif

    typedef struct packed {
        logic        valid;
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [6:0]  f7;
        logic [31:0] imm;
        logic [2:0]  itype;
        logic        illegal;
    } dec_t;

    dec_t exp_q;

    function automatic dec_t reset_val();
        dec_t d = '0;
        d.itype = 3'b111;
        return d;
    endfunction

    // Reference: format table written directly from the ISA encoding rules.
    function automatic dec_t model(input logic [31:0] x);
        dec_t d = '0;
        logic [6:0] op = x[6:0];
        logic [2:0] f3 = x[14:12];
        logic [6:0] f7 = x[31:25];
        int off;
        d.valid  = 1'b1;
        d.opcode = op;
        d.itype  = 3'b111;
        d.illegal = 1'b1;
        if (op == 7'h33) begin
            d.itype = 3'b000; d.rd = x[11:7]; d.f3 = f3; d.rs1 = x[19:15];
            d.rs2 = x[24:20]; d.f7 = f7;
            d.illegal = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)));
        end else if (op == 7'h13 || op == 7'h03 || op == 7'h67) begin
            d.itype = 3'b001; d.rd = x[11:7]; d.f3 = f3; d.rs1 = x[19:15];
            d.illegal = 1'b0;
            if (op == 7'h13 && (f3 == 1 || f3 == 5)) begin
                d.f7 = f7;
                d.imm = 32'(x[24:20]);
                d.illegal = (f3 == 1) ? (f7 != 0) : !(f7 == 0 || f7 == 7'h20);
            end else begin
                off = int'($signed(x[31:20]));
                d.imm = 32'(off);
                if (op == 7'h67) d.illegal = (f3 != 0);
                if (op == 7'h03) d.illegal = (f3 == 3 || f3 == 6 || f3 == 7);
            end
        end else if (op == 7'h23) begin
            d.itype = 3'b010; d.f3 = f3; d.rs1 = x[19:15]; d.rs2 = x[24:20];
            off = int'($signed({x[31:25], x[11:7]}));
            d.imm = 32'(off);
            d.illegal = (f3 > 2);
        end else if (op == 7'h63) begin
            d.itype = 3'b011; d.f3 = f3; d.rs1 = x[19:15]; d.rs2 = x[24:20];
            off = int'($signed({x[31], x[7], x[30:25], x[11:8]})) * 2;
            d.imm = 32'(off);
            d.illegal = (f3 == 2 || f3 == 3);
        end else if (op == 7'h37 || op == 7'h17) begin
            d.itype = 3'b100; d.rd = x[11:7];
            d.imm = 32'(x[31:12]) * 4096;
            d.illegal = 1'b0;
        end else if (op == 7'h6F) begin
            d.itype = 3'b101; d.rd = x[11:7];
            off = int'($signed({x[31], x[19:12], x[20], x[30:21]})) * 2;
            d.imm = 32'(off);
            d.illegal = 1'b0;
        end
`ifndef IDU_ILLEGAL_CHECK_EN
        d.illegal = 1'b0;
`endif
        return d;
    endfunction

    function automatic dec_t observed();
        return {out_valid, opcode, rd, funct3, rs1, rs2, funct7, imm, instr_type, illegal};
    endfunction

    task automatic step(input logic r, input logic v, input logic [31:0] ins);
        @(negedge clk);
        rst = r; in_valid = v; instruction = ins;
        @(posedge clk);
        #1;
        if (r) exp_q = reset_val();
        else if (v) exp_q = model(ins);
        else exp_q.valid = 1'b0;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h00C58533);
        checks++;
        if (observed() !== reset_val()) begin
            errors++;
            $display("FAIL reset: got %h expected %h", observed(), reset_val());
        end
    endtask

    task automatic test_directed();
        logic [31:0] vec [7] = '{32'h00C58533, 32'hFF630293, 32'h00F72823, 32'hFE208CE3,
                                 32'h123450B7, 32'h001000EF, 32'h0000007F};
        logic [31:0] want_imm [7] = '{32'h0, 32'hFFFFFFF6, 32'h10, 32'hFFFFFFF8,
                                      32'h12345000, 32'h800, 32'h0};
        logic [2:0] want_type [7] = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b101, 3'b111};
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 1'b1, vec[i]);
            checks++;
            if (observed() !== exp_q) begin
                errors++;
                $display("FAIL directed_%0d: got %h expected %h", i, observed(), exp_q);
            end
            checks++;
            if (imm !== want_imm[i] || instr_type !== want_type[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed_imm_%0d: imm %h type %b vld %b expected imm %h type %b vld 1",
                         i, imm, instr_type, out_valid, want_imm[i], want_type[i]);
            end
        end
`ifdef IDU_ILLEGAL_CHECK_EN
        checks++;
        if (illegal !== 1'b1) begin
            errors++;
            $display("FAIL illegal_unknown: got %b expected 1", illegal);
        end
`endif
    endtask

    task automatic test_hold();
        step(1'b0, 1'b1, 32'hFF630293);
        step(1'b0, 1'b0, 32'h00C58533);
        checks++;
        if (out_valid !== 1'b0 || rd !== 5'd5 || rs1 !== 5'd6 || imm !== 32'hFFFFFFF6
            || instr_type !== 3'b001) begin
            errors++;
            $display("FAIL hold: vld %b rd %0d rs1 %0d imm %h type %b expected 0 5 6 fffffff6 001",
                     out_valid, rd, rs1, imm, instr_type);
        end
    endtask

    task automatic test_reset_midstream();
        step(1'b0, 1'b1, 32'h00F72823);
        step(1'b1, 1'b1, 32'h123450B7);
        checks++;
        if (observed() !== reset_val()) begin
            errors++;
            $display("FAIL reset_mid: got %h expected %h", observed(), reset_val());
        end
        step(1'b0, 1'b0, 32'h123450B7);
        checks++;
        if (observed() !== reset_val()) begin
            errors++;
            $display("FAIL reset_mid_after: got %h expected %h", observed(), reset_val());
        end
    endtask

    task automatic test_back_to_back_random();
        logic [6:0] ops [10] = '{7'h33, 7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h00};
        logic [31:0] ins;
        logic v, r;
        for (int n = 0; n < 400; n++) begin
            ins = $urandom;
            if ($urandom_range(0, 9) != 0) ins[6:0] = ops[$urandom_range(0, 9)];
            if ($urandom_range(0, 3) == 0) ins[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 39) == 0);
            step(r, v, ins);
            checks++;
            if (observed() !== exp_q) begin
                errors++;
                $display("FAIL random_%0d: ins %h got %h expected %h", n, ins, observed(), exp_q);
            end
        end
    endtask

    initial begin
        exp_q = reset_val();
        test_reset();
        test_directed();
        test_hold();
        test_reset_midstream();
        test_back_to_back_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
